mlx_i2c_target: RTL and testbench
=================================

Name: mlx_i2c_target

Overview:
- I2C target (responder) that emulates the MLX90640 thermal camera's bus interface: 7-bit device address, 16-bit register addresses, 16-bit data words, MSB first.
- Runs on the 24 MHz system clock. Oversamples SCL/SDA; never drives SCL.
- Backs the simulation bench for the camera I2C controller and allows hardware loopback on the S1 Popout pins.
- Register storage is external, reached through a simple synchronous read/write port.

Parameters:
- DEVICE_ADDR, 7'h33, 7-bit address this target answers to.
- SYNC_STAGES, 2, flop stages on scl_in/sda_in before edge detection (minimum 2).

Ports:
- clk  in  1  system clock; must be ≥ 16× SCL frequency.
- reset  in  1  synchronous, active-high.
- scl_in  in  1  raw SCL pin level.
- sda_in  in  1  raw SDA pin level.
- sda_oe  out  1  1 = pull SDA low, 0 = release (open-drain).
- reg_addr  out  16  word address for the current read/write strobe.
- reg_rd_en  out  1  1-cycle read strobe.
- reg_rd_data  in  16  read data, valid exactly 1 clk after reg_rd_en.
- reg_wr_en  out  1  1-cycle write strobe.
- reg_wr_data  out  16  write data, valid while reg_wr_en = 1.
- busy  out  1  high from an address-matched START until STOP.

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset values: sda_oe=0, reg_rd_en=0, reg_wr_en=0, busy=0, reg_addr=0, reg_wr_data=0, internal pointer=0, state=IDLE. Reset mid-transfer releases SDA on the next clk edge.
- Synchronisation: scl/sda pass through SYNC_STAGES flops; edges are found from the last two synced samples.
- START: synced SDA falls while SCL is high. STOP: synced SDA rises while SCL is high.
- Bit timing: SDA is sampled on SCL rising. sda_oe changes only on SCL falling (1 clk after the detected edge).
- States: IDLE, ADDR, ADDR_ACK, PTR_HI, PTR_LO, WR_HI, WR_LO, RX_ACK, RD_HI, RD_LO, MST_ACK, IGNORE.
- A 3-bit bit counter and an 8-bit shift register are shared across all byte states.
- START (including repeated START) from any state -> ADDR; bit counter cleared; pointer kept.
- STOP from any state -> IDLE; sda_oe=0; busy=0; a partial word is discarded with no strobe.
- ADDR: shift 8 bits. If [7:1] == DEVICE_ADDR, go to ADDR_ACK and set busy. Otherwise go to IGNORE: no ACK, no strobes until START/STOP.
- ADDR_ACK: drive 0 for the ACK bit, then:
  - write (R/W=0) -> PTR_HI;
  - read (R/W=1) -> pulse reg_rd_en with reg_addr=pointer on the ACK-bit SCL rising edge, latch reg_rd_data 1 clk later, go to RD_HI.
- Write path:
  - PTR_HI then PTR_LO load the 16-bit pointer, MSB byte first.
  - WR_HI then WR_LO assemble the data word.
  - After the WR_LO ACK: pulse reg_wr_en for exactly 1 clk with reg_addr=pointer and reg_wr_data=word, increment the pointer, return to WR_HI.
  - Every received byte is ACKed (RX_ACK phase).
- Read path:
  - RD_HI shifts out the high byte, RD_LO the low byte.
  - A data bit of 0 gives sda_oe=1; a data bit of 1 gives sda_oe=0.
  - SDA is released during the controller ACK bit between the two bytes.
  - MST_ACK after RD_LO samples the controller's bit:
    - ACK (0): increment the pointer, pulse reg_rd_en on that SCL rising edge, then RD_HI.
    - NACK (1): go to IGNORE and release SDA.
- Pointer arithmetic: 16-bit, wraps 0xFFFF -> 0x0000.
- Strobes: reg_rd_en and reg_wr_en are never high in the same cycle. Each strobe is exactly 1 clk wide.
- Read latency: fetch completes 2 clk after the strobe, well before the next SCL falling edge.

Test Plan:
- Write 0x66, 0x80, 0x0D, 0x19, 0x01, STOP -> ACK on all 5 bytes; one reg_wr_en with reg_addr=0x800D, reg_wr_data=0x1901; busy low after STOP.
- Write 0x66, 0x24, 0x00, repeated START, 0x67, read 4 bytes (ACK, ACK, ACK, NACK), memory 0x2400=0xA5C3, 0x2401=0x0F0F -> SDA bytes A5 C3 0F 0F; reg_rd_en at 0x2400 and 0x2401 only; pointer ends at 0x2401.
- Address 0x64 (target 0x32) -> sda_oe stays 0 through the 9th clock; no strobes; busy stays 0.
- Pointer 0xFFFF, write two words -> strobes at 0xFFFF then 0x0000.
- STOP after 4 bits of WR_LO -> no reg_wr_en; state IDLE.
- Reset asserted while driving a 0 data bit in RD_HI -> sda_oe=0 the next clk; a following transaction ACKs normally.

Source files
------------

// File: rtl/mlx_i2c_target.sv
// mlx_i2c_target: I2C target emulating the MLX90640 bus interface
// (7-bit device address, 16-bit register pointer, 16-bit data words, MSB first).
// Ports:
//   clk, reset       system clock (>= 16x SCL) and synchronous active-high reset
//   scl_in, sda_in   raw bus levels; SCL is never driven
//   sda_oe           1 pulls SDA low (open-drain)
//   reg_addr         word address for the current strobe
//   reg_rd_en        1-clk read strobe; reg_rd_data valid 1 clk later
//   reg_wr_en        1-clk write strobe with reg_wr_data
//   busy             high from an address-matched START until STOP
module mlx_i2c_target #(
    parameter logic [6:0]  DEVICE_ADDR = 7'h33,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    output logic [15:0] reg_addr,
    output logic        reg_rd_en,
    input  logic [15:0] reg_rd_data,
    output logic        reg_wr_en,
    output logic [15:0] reg_wr_data,
    output logic        busy
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR_HI, PTR_LO, WR_HI, WR_LO,
        RX_ACK, RD_HI, RD_LO, MST_ACK, IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic        scl_p_q, sda_p_q;
    state_t      state_q, state_d;
    // Byte state that led into the current ACK state.
    state_t      from_q, from_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  sr_q, sr_d;
    logic [7:0]  lo_q, lo_d;
    logic [15:0] ptr_q, ptr_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic [15:0] reg_addr_q, reg_addr_d;
    logic        rd_en_q, rd_en_d;
    logic        wr_en_q, wr_en_d;
    logic        rd_pend_q, rd_pend_d;
    logic        sda_oe_q, sda_oe_d;
    logic        busy_q, busy_d;

    logic       scl_s, sda_s;
    logic       scl_rise, scl_fall, start_det, stop_det;
    logic       last_bit, addr_match;
    logic [7:0] byte_in;

    assign scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
    assign sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
    assign scl_s      = scl_sync_q[SYNC_STAGES-1];
    assign sda_s      = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise   = scl_s & ~scl_p_q;
    assign scl_fall   = ~scl_s & scl_p_q;
    assign start_det  = scl_s & scl_p_q & sda_p_q & ~sda_s;
    assign stop_det   = scl_s & scl_p_q & ~sda_p_q & sda_s;
    assign byte_in    = {sr_q[6:0], sda_s};
    assign last_bit   = (cnt_q == 3'd7);
    assign addr_match = (byte_in[7:1] == DEVICE_ADDR);

    // State register (synchronisers reset to the idle-bus level).
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_p_q    <= 1'b1;
            sda_p_q    <= 1'b1;
            state_q    <= IDLE;
            from_q     <= IDLE;
            cnt_q      <= '0;
            sr_q       <= '0;
            lo_q       <= '0;
            ptr_q      <= '0;
            wr_data_q  <= '0;
            reg_addr_q <= '0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            rd_pend_q  <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_p_q    <= scl_s;
            sda_p_q    <= sda_s;
            state_q    <= state_d;
            from_q     <= from_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            lo_q       <= lo_d;
            ptr_q      <= ptr_d;
            wr_data_q  <= wr_data_d;
            reg_addr_q <= reg_addr_d;
            rd_en_q    <= rd_en_d;
            wr_en_q    <= wr_en_d;
            rd_pend_q  <= rd_pend_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state logic: all bit-level moves happen on SCL rising.
    always_comb begin
        state_d = state_q;
        from_d  = from_q;
        if (start_det) begin
            state_d = ADDR;
        end else if (stop_det) begin
            state_d = IDLE;
        end else if (scl_rise) begin
            unique case (state_q)
                ADDR: if (last_bit) state_d = addr_match ? ADDR_ACK : IGNORE;
                PTR_HI, PTR_LO, WR_HI, WR_LO: begin
                    if (last_bit) begin
                        state_d = RX_ACK;
                        from_d  = state_q;
                    end
                end
                RX_ACK: begin
                    unique case (from_q)
                        PTR_HI:  state_d = PTR_LO;
                        WR_HI:   state_d = WR_LO;
                        default: state_d = WR_HI;
                    endcase
                end
                // The address byte is still in sr_q; bit 0 is R/W.
                ADDR_ACK: state_d = sr_q[0] ? RD_HI : PTR_HI;
                RD_HI, RD_LO: begin
                    if (last_bit) begin
                        state_d = MST_ACK;
                        from_d  = state_q;
                    end
                end
                MST_ACK: begin
                    if (sda_s)                 state_d = IGNORE;
                    else if (from_q == RD_HI)  state_d = RD_LO;
                    else                       state_d = RD_HI;
                end
                default: ;
            endcase
        end
    end

    // Datapath and outputs.
    always_comb begin
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        lo_d       = lo_q;
        ptr_d      = ptr_q;
        wr_data_d  = wr_data_q;
        reg_addr_d = reg_addr_q;
        rd_en_d    = 1'b0;
        wr_en_d    = 1'b0;
        rd_pend_d  = rd_en_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;

        // Register file answers the cycle after the strobe.
        if (rd_pend_q && state_q == RD_HI) begin
            {sr_d, lo_d} = reg_rd_data;
        end

        if (start_det) begin
            cnt_d    = '0;
            sda_oe_d = 1'b0;
        end else if (stop_det) begin
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (scl_rise) begin
            unique case (state_q)
                ADDR, PTR_HI, PTR_LO, WR_HI, WR_LO: begin
                    sr_d  = byte_in;
                    cnt_d = cnt_q + 3'd1;
                    if (last_bit) begin
                        unique case (state_q)
                            ADDR:    if (addr_match) busy_d = 1'b1;
                            PTR_HI:  ptr_d[15:8]     = byte_in;
                            PTR_LO:  ptr_d[7:0]      = byte_in;
                            WR_HI:   wr_data_d[15:8] = byte_in;
                            default: wr_data_d[7:0]  = byte_in;
                        endcase
                    end
                end
                ADDR_ACK: begin
                    if (sr_q[0]) begin
                        rd_en_d    = 1'b1;
                        reg_addr_d = ptr_q;
                    end
                end
                RX_ACK: begin
                    if (from_q == WR_LO) begin
                        wr_en_d    = 1'b1;
                        reg_addr_d = ptr_q;
                        ptr_d      = ptr_q + 16'd1;
                    end
                end
                RD_HI, RD_LO: begin
                    sr_d  = {sr_q[6:0], 1'b1};
                    cnt_d = cnt_q + 3'd1;
                end
                MST_ACK: begin
                    if (!sda_s && from_q == RD_HI) begin
                        sr_d = lo_q;
                    end else if (!sda_s) begin
                        ptr_d      = ptr_q + 16'd1;
                        reg_addr_d = ptr_q + 16'd1;
                        rd_en_d    = 1'b1;
                    end
                end
                default: ;
            endcase
        end else if (scl_fall) begin
            unique case (state_q)
                ADDR_ACK, RX_ACK: sda_oe_d = 1'b1;
                RD_HI, RD_LO:     sda_oe_d = ~sr_q[7];
                default:          sda_oe_d = 1'b0;
            endcase
        end
    end

    assign sda_oe      = sda_oe_q;
    assign reg_addr    = reg_addr_q;
    assign reg_rd_en   = rd_en_q;
    assign reg_wr_en   = wr_en_q;
    assign reg_wr_data = wr_data_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_mlx_i2c_target.sv
// Testbench for mlx_i2c_target: bit-banged I2C controller, register-file
// model and table-driven write/readback plus directed corner sequences.
module tb_mlx_i2c_target;

    localparam int Q = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        scl_m, sda_m;
    logic        scl_in, sda_in;
    logic        sda_oe;
    logic [15:0] reg_addr;
    logic        reg_rd_en;
    logic [15:0] reg_rd_data;
    logic        reg_wr_en;
    logic [15:0] reg_wr_data;
    logic        busy;

    always #21 clk = ~clk;

    assign scl_in = scl_m;
    assign sda_in = sda_m & ~sda_oe;

    mlx_i2c_target #(
        .DEVICE_ADDR(7'h33),
        .SYNC_STAGES(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .scl_in     (scl_in),
        .sda_in     (sda_in),
        .sda_oe     (sda_oe),
        .reg_addr   (reg_addr),
        .reg_rd_en  (reg_rd_en),
        .reg_rd_data(reg_rd_data),
        .reg_wr_en  (reg_wr_en),
        .reg_wr_data(reg_wr_data),
        .busy       (busy)
    );

    // Register file model and strobe monitor.
    logic [15:0] mem [0:65535];
    logic [15:0] wr_addr_log [0:63];
    logic [15:0] wr_data_log [0:63];
    logic [15:0] rd_log [0:63];
    int wr_cnt = 0;
    int rd_cnt = 0;
    int oe_cnt = 0;
    int bad_cnt = 0;
    logic rd_prev = 1'b0;
    logic wr_prev = 1'b0;

    always @(posedge clk) begin
        if (reg_wr_en) begin
            mem[reg_addr] <= reg_wr_data;
            wr_addr_log[wr_cnt[5:0]] <= reg_addr;
            wr_data_log[wr_cnt[5:0]] <= reg_wr_data;
            wr_cnt <= wr_cnt + 1;
        end
        if (reg_rd_en) begin
            reg_rd_data <= mem[reg_addr];
            rd_log[rd_cnt[5:0]] <= reg_addr;
            rd_cnt <= rd_cnt + 1;
        end
        bad_cnt <= bad_cnt + int'(reg_rd_en && reg_wr_en)
                 + int'(reg_rd_en && rd_prev) + int'(reg_wr_en && wr_prev);
        rd_prev <= reg_rd_en;
        wr_prev <= reg_wr_en;
        if (sda_oe) oe_cnt <= oe_cnt + 1;
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_clk(input logic b, output logic r);
        sda_m = b;
        tick(Q);
        scl_m = 1'b1;
        tick(Q);
        r = sda_in;
        tick(Q);
        scl_m = 1'b0;
        tick(Q);
    endtask

    task automatic start_c();
        sda_m = 1'b1;
        tick(Q);
        scl_m = 1'b1;
        tick(Q);
        sda_m = 1'b0;
        tick(Q);
        scl_m = 1'b0;
        tick(Q);
    endtask

    task automatic stop_c();
        sda_m = 1'b0;
        tick(Q);
        scl_m = 1'b1;
        tick(Q);
        sda_m = 1'b1;
        tick(Q);
    endtask

    // ack output is the line level during the 9th clock (0 = ACK).
    task automatic wr_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_clk(b[i], r);
        bit_clk(1'b1, ack);
    endtask

    task automatic rd_byte(input logic nack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_clk(1'b1, r);
            d[i] = r;
        end
        bit_clk(nack, r);
    endtask

    typedef struct {
        logic [15:0] ptr;
        logic [15:0] data;
        logic [4:0]  exp_acks;
        logic [15:0] exp_addr;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic [4:0]  a;
        logic [6:0]  a7;
        logic        ak;
        logic [7:0]  d0, d1, d2, d3;
        int w0, r0, o0;

        vecs[0] = '{16'h800D, 16'h1901, 5'b0, 16'h800D, 16'h1901};
        vecs[1] = '{16'h2400, 16'hA5C3, 5'b0, 16'h2400, 16'hA5C3};
        vecs[2] = '{16'h2401, 16'h0F0F, 5'b0, 16'h2401, 16'h0F0F};
        vecs[3] = '{16'h0000, 16'hFFFF, 5'b0, 16'h0000, 16'hFFFF};
        vecs[4] = '{16'h1234, 16'h0000, 5'b0, 16'h1234, 16'h0000};

        reset = 1'b1;
        scl_m = 1'b1;
        sda_m = 1'b1;
        tick(4);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_reg_addr", 32'(reg_addr), 32'd0);
        check("rst_wr_data", 32'(reg_wr_data), 32'd0);
        check("rst_strobes", 32'({reg_rd_en, reg_wr_en}), 32'd0);
        reset = 1'b0;
        tick(4);

        // Table: one-word writes, each closed by STOP.
        foreach (vecs[i]) begin
            w0 = wr_cnt;
            start_c();
            wr_byte(8'h66, a[4]);
            wr_byte(vecs[i].ptr[15:8], a[3]);
            wr_byte(vecs[i].ptr[7:0], a[2]);
            wr_byte(vecs[i].data[15:8], a[1]);
            wr_byte(vecs[i].data[7:0], a[0]);
            check($sformatf("v%0d_busy_mid", i), 32'(busy), 32'd1);
            stop_c();
            tick(4);
            check($sformatf("v%0d_acks", i), 32'(a), 32'(vecs[i].exp_acks));
            check($sformatf("v%0d_busy_end", i), 32'(busy), 32'd0);
            check($sformatf("v%0d_wr_count", i), 32'(wr_cnt - w0), 32'd1);
            check($sformatf("v%0d_wr_addr", i), 32'(wr_addr_log[w0[5:0]]),
                  32'(vecs[i].exp_addr));
            check($sformatf("v%0d_wr_data", i), 32'(wr_data_log[w0[5:0]]),
                  32'(vecs[i].exp_data));
        end

        // Pointer write, repeated START, 4-byte read ending in NACK.
        r0 = rd_cnt;
        start_c();
        wr_byte(8'h66, a[4]);
        wr_byte(8'h24, a[3]);
        wr_byte(8'h00, a[2]);
        start_c();
        wr_byte(8'h67, a[1]);
        rd_byte(1'b0, d0);
        rd_byte(1'b0, d1);
        rd_byte(1'b0, d2);
        rd_byte(1'b1, d3);
        stop_c();
        tick(4);
        check("rd_acks", 32'(a[4:1]), 32'd0);
        check("rd_bytes", {d0, d1, d2, d3}, 32'hA5C30F0F);
        check("rd_count", 32'(rd_cnt - r0), 32'd2);
        check("rd_addr0", 32'(rd_log[r0[5:0]]), 32'h2400);
        check("rd_addr1", 32'(rd_log[6'(r0 + 1)]), 32'h2401);
        check("rd_ptr_end", 32'(reg_addr), 32'h2401);

        // Foreign address 0x32 must be ignored entirely.
        w0 = wr_cnt;
        r0 = rd_cnt;
        o0 = oe_cnt;
        a7 = 7'h32;
        start_c();
        wr_byte({a7, 1'b0}, ak);
        check("foreign_nack", 32'(ak), 32'd1);
        check("foreign_busy", 32'(busy), 32'd0);
        wr_byte(8'h00, ak);
        stop_c();
        tick(4);
        check("foreign_oe", 32'(oe_cnt - o0), 32'd0);
        check("foreign_strobes", 32'((wr_cnt - w0) + (rd_cnt - r0)), 32'd0);

        // Pointer wrap across two words.
        w0 = wr_cnt;
        start_c();
        wr_byte(8'h66, ak);
        wr_byte(8'hFF, ak);
        wr_byte(8'hFF, ak);
        wr_byte(8'h11, ak);
        wr_byte(8'h22, ak);
        wr_byte(8'h33, ak);
        wr_byte(8'h44, ak);
        stop_c();
        tick(4);
        check("wrap_count", 32'(wr_cnt - w0), 32'd2);
        check("wrap_addr0", 32'(wr_addr_log[w0[5:0]]), 32'hFFFF);
        check("wrap_addr1", 32'(wr_addr_log[6'(w0 + 1)]), 32'h0000);
        check("wrap_data1", 32'(wr_data_log[6'(w0 + 1)]), 32'h3344);

        // STOP in the middle of the low data byte.
        w0 = wr_cnt;
        start_c();
        wr_byte(8'h66, ak);
        wr_byte(8'h10, ak);
        wr_byte(8'h00, ak);
        wr_byte(8'hAB, ak);
        for (int i = 0; i < 4; i++) bit_clk(1'b1, ak);
        stop_c();
        tick(4);
        check("partial_no_wr", 32'(wr_cnt - w0), 32'd0);
        check("partial_idle", 32'(dut.state_q), 32'd0);
        check("partial_busy", 32'(busy), 32'd0);

        // Reset while the target drives a 0 data bit (0x2401 = 0x0F0F).
        start_c();
        wr_byte(8'h66, ak);
        wr_byte(8'h24, ak);
        wr_byte(8'h01, ak);
        start_c();
        wr_byte(8'h67, ak);
        check("rst_mid_drive", 32'(sda_oe), 32'd1);
        reset = 1'b1;
        tick(1);
        check("rst_mid_release", 32'(sda_oe), 32'd0);
        reset = 1'b0;
        sda_m = 1'b1;
        scl_m = 1'b1;
        tick(Q);
        w0 = wr_cnt;
        start_c();
        wr_byte(8'h66, a[4]);
        wr_byte(8'h12, a[3]);
        wr_byte(8'h34, a[2]);
        wr_byte(8'h56, a[1]);
        wr_byte(8'h78, a[0]);
        stop_c();
        tick(4);
        check("post_rst_acks", 32'(a), 32'd0);
        check("post_rst_wr", 32'(wr_cnt - w0), 32'd1);
        check("post_rst_addr", 32'(wr_addr_log[w0[5:0]]), 32'h1234);
        check("post_rst_data", 32'(wr_data_log[w0[5:0]]), 32'h5678);

        check("strobe_rules", 32'(bad_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
